midi_msg_tx: RTL and testbench

- Encodes channel-voice and system-reset requests into a MIDI byte stream for the UART transmitter.
- It is the transmit counterpart of the MIDI receive FSM. It uses the same status codes and handles one message per request.
- It supports optional running status with a timeout.
- Upstream is the synth control/sequencer logic, with a valid/ready request port. Downstream is the UART TX byte port, with a valid/ready byte handshake.

---
 rtl/midi_pkg.sv | 41 ++++
 rtl/midi_rs_timer.sv | 39 +++
 rtl/midi_msg_tx.sv | 155 +++++++++++++++
 tb/tb_midi_msg_tx.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// Shared MIDI constants: status codes, request type encodings, TX FSM states.
package midi_pkg;

    // Status nibbles (upper half of the status byte) and the one-byte system reset.
    localparam logic [3:0] S_NOTE_OFF = 4'h8;
    localparam logic [3:0] S_NOTE_ON  = 4'h9;
    localparam logic [3:0] S_CC       = 4'hB;
    localparam logic [3:0] S_PROGRAM  = 4'hC;
    localparam logic [7:0] S_RESET    = 8'hFF;

    // Request type encodings on msg_type; 5-7 are illegal.
    localparam logic [2:0] MT_NOTE_OFF = 3'd0;
    localparam logic [2:0] MT_NOTE_ON  = 3'd1;
    localparam logic [2:0] MT_CC       = 3'd2;
    localparam logic [2:0] MT_PROGRAM  = 3'd3;
    localparam logic [2:0] MT_RESET    = 3'd4;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StSendStat = 2'd1,
        StSendD1   = 2'd2,
        StSendD2   = 2'd3
    } tx_state_e;

    function automatic logic type_legal(input logic [2:0] t);
        return (t <= MT_RESET);
    endfunction

    function automatic logic [7:0] status_byte(input logic [2:0] t, input logic [3:0] chan);
        logic [7:0] s;
        case (t)
            MT_NOTE_OFF: s = {S_NOTE_OFF, chan};
            MT_NOTE_ON:  s = {S_NOTE_ON, chan};
            MT_CC:       s = {S_CC, chan};
            MT_PROGRAM:  s = {S_PROGRAM, chan};
            default:     s = S_RESET;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/midi_rs_timer.sv
// Idle counter for running-status expiry. Pulses expired on the cycle the count
// reaches RS_TIMEOUT, then saturates. RS_TIMEOUT = 0 disables expiry.
module midi_rs_timer #(
    parameter logic [23:0] RS_TIMEOUT = 24'd2_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [23:0] cnt_q, cnt_d;
    logic        at_last;

    // Counter is one step short of the limit; the next enabled cycle reaches it.
    assign at_last = (RS_TIMEOUT != 24'd0) && (cnt_q == RS_TIMEOUT - 24'd1);
    assign expired = en && !clr && at_last;

    // Next count: clear wins, otherwise count up until saturated at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 24'd0;
        end else if (en && (RS_TIMEOUT != 24'd0) && (cnt_q != RS_TIMEOUT)) begin
            cnt_d = cnt_q + 24'd1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 24'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/midi_msg_tx.sv
// MIDI message encoder: turns one request into a status/data byte sequence for the
// UART, optionally omitting a repeated status byte (running status).
module midi_msg_tx import midi_pkg::*; #(
    parameter bit          RUNNING_STATUS = 1'b1,
    parameter logic [23:0] RS_TIMEOUT     = 24'd2_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       msg_valid,
    output logic       msg_ready,
    input  logic [2:0] msg_type,
    input  logic [3:0] msg_chan,
    input  logic [6:0] msg_d1,
    input  logic [6:0] msg_d2,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       err,
    output logic [1:0] state_o
);

    tx_state_e  state_q, state_d;
    logic [2:0] type_q, type_d;
    logic [7:0] stat_q, stat_d;
    logic [6:0] d1_q, d1_d;
    logic [6:0] d2_q, d2_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       err_q, err_d;
    logic [7:0] last_status_q, last_status_d;
    logic       last_valid_q, last_valid_d;

    logic       accept, hs, rs_hit, expired;
    logic [7:0] new_status;

    assign msg_ready  = (state_q == StIdle);
    assign tx_valid   = (state_q != StIdle);
    assign tx_data    = tx_data_q;
    assign err        = err_q;
    assign state_o    = state_q;
    assign accept     = msg_valid && msg_ready;
    assign hs         = tx_valid && tx_ready;
    assign new_status = status_byte(msg_type, msg_chan);
    // Acceptance reads the registered last_status, so a same-cycle expiry is not yet seen.
    assign rs_hit     = RUNNING_STATUS && last_valid_q && (last_status_q == new_status) &&
                        (msg_type != MT_RESET);

    midi_rs_timer #(
        .RS_TIMEOUT(RS_TIMEOUT)
    ) u_rs_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (!msg_ready || accept),
        .en     (msg_ready && !accept),
        .expired(expired)
    );

    // Next-state, byte load and running-status bookkeeping.
    always_comb begin
        state_d       = state_q;
        type_d        = type_q;
        stat_d        = stat_q;
        d1_d          = d1_q;
        d2_d          = d2_q;
        tx_data_d     = tx_data_q;
        err_d         = 1'b0;
        last_status_d = last_status_q;
        last_valid_d  = last_valid_q;

        if (expired) begin
            last_valid_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (!type_legal(msg_type)) begin
                        err_d = 1'b1;
                    end else begin
                        type_d = msg_type;
                        stat_d = new_status;
                        d1_d   = msg_d1;
                        d2_d   = msg_d2;
                        if (rs_hit) begin
                            state_d   = StSendD1;
                            tx_data_d = {1'b0, msg_d1};
                        end else begin
                            state_d   = StSendStat;
                            tx_data_d = new_status;
                        end
                    end
                end
            end
            StSendStat: begin
                if (hs) begin
                    if (RUNNING_STATUS) begin
                        if (type_q == MT_RESET) begin
                            last_valid_d = 1'b0;
                        end else begin
                            last_status_d = stat_q;
                            last_valid_d  = 1'b1;
                        end
                    end
                    if (type_q == MT_RESET) begin
                        state_d = StIdle;
                    end else begin
                        state_d   = StSendD1;
                        tx_data_d = {1'b0, d1_q};
                    end
                end
            end
            StSendD1: begin
                if (hs) begin
                    if (type_q == MT_PROGRAM) begin
                        state_d = StIdle;
                    end else begin
                        state_d   = StSendD2;
                        tx_data_d = {1'b0, d2_q};
                    end
                end
            end
            StSendD2: begin
                if (hs) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            type_q        <= 3'd0;
            stat_q        <= 8'h00;
            d1_q          <= 7'd0;
            d2_q          <= 7'd0;
            tx_data_q     <= 8'h00;
            err_q         <= 1'b0;
            last_status_q <= 8'h00;
            last_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            type_q        <= type_d;
            stat_q        <= stat_d;
            d1_q          <= d1_d;
            d2_q          <= d2_d;
            tx_data_q     <= tx_data_d;
            err_q         <= err_d;
            last_status_q <= last_status_d;
            last_valid_q  <= last_valid_d;
        end
    end

endmodule

// File: tb/tb_midi_msg_tx.sv
// Directed bench for midi_msg_tx: one running-status instance and one without,
// both with a short timeout; sel picks which one the stimulus talks to.
module tb_midi_msg_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sel = 1'b0;
    logic       msg_valid = 1'b0;
    logic [2:0] msg_type = 3'd0;
    logic [3:0] msg_chan = 4'd0;
    logic [6:0] msg_d1 = 7'd0;
    logic [6:0] msg_d2 = 7'd0;
    logic       tx_ready = 1'b1;

    logic       ready_a, ready_b, valid_a, valid_b, err_a, err_b;
    logic [7:0] data_a, data_b;
    logic [1:0] st_a, st_b;

    logic       cur_ready, cur_valid, cur_err;
    logic [7:0] cur_data;
    logic [1:0] cur_st;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int n;
    logic [7:0] bq[$];
    int         cq[$];

    always #5 clk = ~clk;

    midi_msg_tx #(
        .RUNNING_STATUS(1'b1),
        .RS_TIMEOUT    (24'd10)
    ) u_dut_a (
        .clk      (clk),
        .rst      (rst),
        .msg_valid(msg_valid && !sel),
        .msg_ready(ready_a),
        .msg_type (msg_type),
        .msg_chan (msg_chan),
        .msg_d1   (msg_d1),
        .msg_d2   (msg_d2),
        .tx_data  (data_a),
        .tx_valid (valid_a),
        .tx_ready (tx_ready),
        .err      (err_a),
        .state_o  (st_a)
    );

    midi_msg_tx #(
        .RUNNING_STATUS(1'b0),
        .RS_TIMEOUT    (24'd10)
    ) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .msg_valid(msg_valid && sel),
        .msg_ready(ready_b),
        .msg_type (msg_type),
        .msg_chan (msg_chan),
        .msg_d1   (msg_d1),
        .msg_d2   (msg_d2),
        .tx_data  (data_b),
        .tx_valid (valid_b),
        .tx_ready (tx_ready),
        .err      (err_b),
        .state_o  (st_b)
    );

    assign cur_ready = sel ? ready_b : ready_a;
    assign cur_valid = sel ? valid_b : valid_a;
    assign cur_err   = sel ? err_b : err_a;
    assign cur_data  = sel ? data_b : data_a;
    assign cur_st    = sel ? st_b : st_a;

    // Byte log: every UART handshake with the edge index it happened on.
    always @(posedge clk) begin
        if (cur_valid === 1'b1 && tx_ready) begin
            bq.push_back(cur_data);
            cq.push_back(cyc);
        end
        cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a request at a negedge; it is accepted at the following posedge.
    task automatic send(input logic [2:0] t, input logic [3:0] c,
                        input logic [6:0] a, input logic [6:0] b);
        msg_type  = t;
        msg_chan  = c;
        msg_d1    = a;
        msg_d2    = b;
        msg_valid = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc   = cyc - 1;
        msg_valid = 1'b0;
    endtask

    // Count negedges with msg_ready low; stops at the first ready negedge (bounded).
    task automatic wait_done(output int busy);
        busy = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cur_ready === 1'b1) break;
            busy++;
        end
    endtask

    task automatic expect_bytes(input string tag, input int cnt, input logic [7:0] e0,
                                input logic [7:0] e1, input logic [7:0] e2, input bit contig);
        logic [7:0] e[3];
        e[0] = e0;
        e[1] = e1;
        e[2] = e2;
        chk({tag, " count"}, bq.size(), cnt);
        for (int i = 0; i < cnt && i < bq.size(); i++) begin
            chk($sformatf("%s byte%0d", tag, i), bq[i], e[i]);
        end
        if (contig && bq.size() == cnt && cnt > 0) begin
            chk({tag, " first"}, cq[0], acc_cyc + 1);
            chk({tag, " span"}, cq[cnt-1] - cq[0], cnt - 1);
        end
        bq.delete();
        cq.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst state", cur_st, 2'd0);
        chk("rst ready", cur_ready, 1'b1);
        chk("rst valid", cur_valid, 1'b0);
        chk("rst data", cur_data, 8'h00);
        chk("rst err", cur_err, 1'b0);
        rst = 1'b0;
        bq.delete();
        cq.delete();

        // Fresh NOTE_ON ch3: full message, three back-to-back bytes
        send(3'd1, 4'd3, 7'd60, 7'd100);
        wait_done(n);
        chk("on3 busy", n, 3);
        expect_bytes("on3", 3, 8'h93, 8'h3C, 8'h64, 1'b1);

        // Same status right after: running status drops the status byte
        send(3'd1, 4'd3, 7'd62, 7'd0);
        wait_done(n);
        chk("on3rs busy", n, 2);
        expect_bytes("on3rs", 2, 8'h3E, 8'h00, 8'h00, 1'b1);

        // Different channel: status byte back
        send(3'd1, 4'd4, 7'd62, 7'd0);
        wait_done(n);
        expect_bytes("on4", 3, 8'h94, 8'h3E, 8'h00, 1'b1);

        // PROGRAM with 4-cycle stalls per byte
        tx_ready = 1'b0;
        send(3'd3, 4'd0, 7'd5, 7'd99);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("pgm stall0 valid", cur_valid, 1'b1);
            chk("pgm stall0 data", cur_data, 8'hC0);
        end
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("pgm stall1 valid", cur_valid, 1'b1);
            chk("pgm stall1 data", cur_data, 8'h05);
        end
        tx_ready = 1'b1;
        @(negedge clk);
        chk("pgm done state", cur_st, 2'd0);
        expect_bytes("pgm", 2, 8'hC0, 8'h05, 8'h00, 1'b0);

        // RESET is one byte and forgets running status
        send(3'd4, 4'd0, 7'd0, 7'd0);
        wait_done(n);
        chk("reset busy", n, 1);
        expect_bytes("reset", 1, 8'hFF, 8'h00, 8'h00, 1'b1);
        send(3'd2, 4'd0, 7'd7, 7'd127);
        wait_done(n);
        expect_bytes("cc0", 3, 8'hB0, 8'h07, 8'h7F, 1'b1);

        // Timeout of 10: 10 idle cycles expire the status, 9 do not
        send(3'd1, 4'd1, 7'd1, 7'd2);
        wait_done(n);
        expect_bytes("on1", 3, 8'h91, 8'h01, 8'h02, 1'b1);
        repeat (10) @(negedge clk);
        send(3'd1, 4'd1, 7'd1, 7'd2);
        wait_done(n);
        expect_bytes("on1 gap10", 3, 8'h91, 8'h01, 8'h02, 1'b1);
        repeat (9) @(negedge clk);
        send(3'd1, 4'd1, 7'd1, 7'd2);
        wait_done(n);
        expect_bytes("on1 gap9", 2, 8'h01, 8'h02, 8'h00, 1'b1);

        // Illegal type: accepted, single err pulse, nothing sent, status kept
        send(3'd6, 4'd1, 7'd9, 7'd9);
        @(negedge clk);
        chk("ill err", cur_err, 1'b1);
        chk("ill valid", cur_valid, 1'b0);
        chk("ill state", cur_st, 2'd0);
        @(negedge clk);
        chk("ill err off", cur_err, 1'b0);
        send(3'd1, 4'd1, 7'd3, 7'd4);
        wait_done(n);
        expect_bytes("after ill", 2, 8'h03, 8'h04, 8'h00, 1'b1);

        // Reset during SEND_D1 drops the message and forgets running status
        tx_ready = 1'b0;
        send(3'd1, 4'd1, 7'd5, 7'd6);
        @(negedge clk);
        chk("mid d1 state", cur_st, 2'd2);
        rst = 1'b1;
        @(negedge clk);
        chk("mid rst valid", cur_valid, 1'b0);
        chk("mid rst state", cur_st, 2'd0);
        rst = 1'b0;
        tx_ready = 1'b1;
        bq.delete();
        cq.delete();
        send(3'd1, 4'd1, 7'd5, 7'd6);
        wait_done(n);
        expect_bytes("post rst", 3, 8'h91, 8'h05, 8'h06, 1'b1);

        // No running status: status byte every time
        sel = 1'b1;
        @(negedge clk);
        send(3'd1, 4'd3, 7'd62, 7'd0);
        wait_done(n);
        expect_bytes("nrs first", 3, 8'h93, 8'h3E, 8'h00, 1'b1);
        send(3'd1, 4'd3, 7'd62, 7'd0);
        wait_done(n);
        chk("nrs busy", n, 3);
        expect_bytes("nrs repeat", 3, 8'h93, 8'h3E, 8'h00, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
